// File: rtl/mac_share_arbiter.sv
// rtl/mac_share_arbiter.sv - two-requester round-robin share of one external FP MAC with per-requester accumulators.
// Optional stall counter enabled by defining MAC_SHARE_STALL_CNT_EN.
module mac_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][DATA_W-1:0] req_a,
  input  logic [1:0][DATA_W-1:0] req_b,
  input  logic [1:0]             req_first,
  input  logic [1:0]             req_last,
  output logic [DATA_W-1:0]      mac_a,
  output logic [DATA_W-1:0]      mac_b,
  output logic [DATA_W-1:0]      mac_c,
  output logic [2:0]             mac_rnd,
  input  logic [DATA_W-1:0]      mac_z,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic                   res_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} acc_state_t;

  acc_state_t                st [2];
  acc_state_t                st_nxt [2];
  logic [1:0][DATA_W-1:0]    acc, acc_nxt;
  logic [1:0]                err_seq, err_seq_nxt;
  logic                      rr, rr_nxt;
  logic                      res_valid_nxt;
  logic [DATA_W-1:0]         res_data_nxt;
  logic                      res_id_nxt;

  logic                      res_free;
  logic [1:0]                elig;
  logic                      gnt_any;
  logic                      gnt;

  assign mac_rnd = 3'b000;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st[0]     <= CLOSED;
      st[1]     <= CLOSED;
      acc       <= '0;
      err_seq   <= '0;
      rr        <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else begin
      st[0]     <= st_nxt[0];
      st[1]     <= st_nxt[1];
      acc       <= acc_nxt;
      err_seq   <= err_seq_nxt;
      rr        <= rr_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      res_id    <= res_id_nxt;
    end
  end

  always_comb begin
    st_nxt[0]     = st[0];
    st_nxt[1]     = st[1];
    acc_nxt       = acc;
    err_seq_nxt   = err_seq;
    rr_nxt        = rr;
    res_valid_nxt = res_valid;
    res_data_nxt  = res_data;
    res_id_nxt    = res_id;
    req_ready     = 2'b00;
    mac_a         = '0;
    mac_b         = '0;
    mac_c         = '0;

    // A last term needs the result register free; non-last terms never wait on it.
    res_free = !res_valid || res_ready;
    elig[0]  = req_valid[0] && (!req_last[0] || res_free);
    elig[1]  = req_valid[1] && (!req_last[1] || res_free);
    gnt_any  = reset_n && (elig != 2'b00);
    gnt      = elig[rr] ? rr : !rr;

    if (gnt_any) begin
      req_ready = 2'b01 << gnt;
      mac_a     = req_a[gnt];
      mac_b     = req_b[gnt];
      if (!req_first[gnt] && st[gnt] == OPEN)
        mac_c = acc[gnt];
      if (!req_first[gnt] && st[gnt] == CLOSED)
        err_seq_nxt[gnt] = 1'b1;
      rr_nxt = !gnt;
      if (req_last[gnt]) begin
        st_nxt[gnt]   = CLOSED;
        acc_nxt[gnt]  = '0;
        res_valid_nxt = 1'b1;
        res_data_nxt  = mac_z;
        res_id_nxt    = gnt;
      end else begin
        st_nxt[gnt]  = OPEN;
        acc_nxt[gnt] = mac_z;
        if (res_valid && res_ready)
          res_valid_nxt = 1'b0;
      end
    end else if (res_valid && res_ready) begin
      res_valid_nxt = 1'b0;
    end

    busy = reset_n && (st[0] == OPEN || st[1] == OPEN || res_valid);
  end

`ifdef MAC_SHARE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      stall_q <= '0;
    else if ((req_valid & ~req_ready) != 2'b00 && stall_q != {CNT_W{1'b1}})
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb/tb_mac_share_arbiter.sv - randomized and directed bench for mac_share_arbiter against a real-valued reference model.
module tb_mac_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        req_valid, req_ready, req_first, req_last;
  logic [1:0][DW-1:0] req_a, req_b;
  logic [DW-1:0]     mac_a, mac_b, mac_c, mac_z, res_data;
  logic [2:0]        mac_rnd;
  logic              res_valid, res_ready, res_id, busy;
  logic [CW-1:0]     stall_cnt;

  always #5 clk = ~clk;

  mac_share_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_first(req_first), .req_last(req_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_rnd(mac_rnd), .mac_z(mac_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  // Operands are small non-negative integers, so single precision is exact and truncation suffices.
  function automatic real sp2r(input logic [31:0] s);
    logic [63:0] d;
    int ee;
    if (s[30:23] == 8'd0) return 0.0;
    ee = int'(s[30:23]) + 896;
    d = {s[31], ee[10:0], s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real x);
    logic [63:0] d;
    int ee;
    if (x == 0.0) return 32'd0;
    d = $realtobits(x);
    ee = int'(d[62:52]) - 896;
    return {d[63], ee[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_mac(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return r2sp(sp2r(a) * sp2r(b) + sp2r(c));
  endfunction

  assign mac_z = fp_mac(mac_a, mac_b, mac_c);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  int  m_rr;
  bit  m_open [2];
  real m_acc [2];
  bit  m_rv;
  real m_rdata;
  int  m_rid;
  bit  m_err [2];
  int  m_stall;

  typedef struct {int a; int b; bit f; bit l;} term_t;
  term_t q0[$];
  term_t q1[$];
  int    gq[$];
  logic [31:0] popped[$];

  task automatic model_reset();
    m_rr = 0; m_open[0] = 0; m_open[1] = 0; m_acc[0] = 0.0; m_acc[1] = 0.0;
    m_rv = 0; m_rdata = 0.0; m_rid = 0; m_err[0] = 0; m_err[1] = 0; m_stall = 0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      req_valid = 2'b11; req_first = 2'b01; req_last = 2'b10;
      req_a[0] = r2sp(3.0); req_b[0] = r2sp(2.0);
      req_a[1] = r2sp(5.0); req_b[1] = r2sp(1.0);
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_mac_a", mac_a, 0);
      check("rst_mac_b", mac_b, 0);
      check("rst_mac_c", mac_c, 0);
      check("rst_mac_rnd", mac_rnd, 0);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    req_valid = 2'b00;
    model_reset();
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_err_seq", dut.err_seq, 0);
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] f, input logic [1:0] l,
                      input int a0, input int b0, input int a1, input int b1, input logic rdy,
                      output bit gany, output int g, output logic [1:0] robs);
    real ar [2];
    real br [2];
    bit  e0, e1, fr;
    logic [1:0] exp_ready;
    real c, z;
    ar[0] = real'(a0); br[0] = real'(b0); ar[1] = real'(a1); br[1] = real'(b1);
    req_valid = v; req_first = f; req_last = l; res_ready = rdy;
    req_a[0] = r2sp(ar[0]); req_b[0] = r2sp(br[0]);
    req_a[1] = r2sp(ar[1]); req_b[1] = r2sp(br[1]);
    @(negedge clk);
    fr = !m_rv || rdy;
    e0 = v[0] && (!l[0] || fr);
    e1 = v[1] && (!l[1] || fr);
    gany = e0 || e1;
    g = (m_rr == 0) ? (e0 ? 0 : 1) : (e1 ? 1 : 0);
    exp_ready = !gany ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
    c = (gany && !f[g] && m_open[g]) ? m_acc[g] : 0.0;
    check("req_ready", req_ready, exp_ready);
    check("mac_a", mac_a, gany ? r2sp(ar[g]) : 32'd0);
    check("mac_b", mac_b, gany ? r2sp(br[g]) : 32'd0);
    check("mac_c", mac_c, r2sp(c));
    check("res_valid", res_valid, m_rv);
    check("res_data", res_data, r2sp(m_rdata));
    check("res_id", res_id, m_rid);
    check("busy", busy, m_open[0] || m_open[1] || m_rv);
    check("stall_cnt", stall_cnt, m_stall);
    robs = req_ready;
    if (res_valid && rdy) popped.push_back(res_data);
`ifdef MAC_SHARE_STALL_CNT_EN
    if ((v & ~exp_ready) != 2'b00 && m_stall < 65535) m_stall++;
`endif
    if (gany) begin
      if (!f[g] && !m_open[g]) m_err[g] = 1;
      z = ar[g] * br[g] + c;
      if (l[g]) begin
        m_rv = 1; m_rdata = z; m_rid = g; m_acc[g] = 0.0; m_open[g] = 0;
      end else begin
        m_acc[g] = z; m_open[g] = 1;
        if (m_rv && rdy) m_rv = 0;
      end
      m_rr = 1 - g;
    end else if (m_rv && rdy) begin
      m_rv = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_queues(input int budget, input int rdy_pct, input int gap_pct);
    int n = 0;
    bit gany;
    int g;
    logic [1:0] robs;
    logic [1:0] v, f, l;
    int a0, b0, a1, b1;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      v = 0; f = 0; l = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      if (q0.size() != 0 && $urandom_range(99) >= gap_pct) begin
        v[0] = 1; f[0] = q0[0].f; l[0] = q0[0].l; a0 = q0[0].a; b0 = q0[0].b;
      end
      if (q1.size() != 0 && $urandom_range(99) >= gap_pct) begin
        v[1] = 1; f[1] = q1[0].f; l[1] = q1[0].l; a1 = q1[0].a; b1 = q1[0].b;
      end
      step(v, f, l, a0, b0, a1, b1, $urandom_range(99) < rdy_pct, gany, g, robs);
      if (gany) begin
        gq.push_back(g);
        if (g == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
      n++;
    end
    check("drain_left", q0.size() + q1.size(), 0);
  endtask

  bit gany_t;
  int g_t;
  logic [1:0] ro;

  initial begin
    reset_n = 1'b0; req_valid = 0; req_first = 0; req_last = 0; res_ready = 0;
    req_a = '0; req_b = '0;
    do_reset(2);

    // Solo accumulation
    step(2'b01, 2'b01, 2'b00, 1, 2, 0, 0, 1'b0, gany_t, g_t, ro);
    step(2'b01, 2'b00, 2'b01, 3, 1, 0, 0, 1'b0, gany_t, g_t, ro);
    check("solo_res_valid", res_valid, 1);
    check("solo_res_data", res_data, 32'h40A00000);
    check("solo_res_id", res_id, 0);
    step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1, gany_t, g_t, ro);

    // Contention from reset
    do_reset(1);
    gq.delete(); popped.delete();
    q0.push_back('{1, 2, 1, 0}); q0.push_back('{3, 1, 0, 1});
    q1.push_back('{2, 2, 1, 0}); q1.push_back('{2, 1, 0, 1});
    run_queues(20, 100, 0);
    step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1, gany_t, g_t, ro);
    check("cont_ngrants", gq.size(), 4);
    if (gq.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("cont_grant%0d", i), gq[i], i % 2);
    end
    check("cont_npop", popped.size(), 2);
    if (popped.size() == 2) begin
      check("cont_pop0", popped[0], 32'h40A00000);
      check("cont_pop1", popped[1], 32'h40C00000);
    end

    // Backpressure: ch1 last blocked while ch0 keeps accumulating
    do_reset(1);
    step(2'b10, 2'b10, 2'b10, 0, 0, 2, 2, 1'b0, gany_t, g_t, ro);
    for (int i = 0; i < 3; i++) begin
      step(2'b11, (i == 0) ? 2'b11 : 2'b10, 2'b10, 1, 1, 1, 1, 1'b0, gany_t, g_t, ro);
      check($sformatf("bp_ready%0d", i), ro, 2'b01);
    end
    step(2'b11, 2'b10, 2'b10, 1, 1, 1, 1, 1'b1, gany_t, g_t, ro);
    check("bp_release", ro, 2'b10);
    check("bp_res_data", res_data, 32'h3F800000);
    check("bp_res_id", res_id, 1);

    // One-term accumulation
    do_reset(1);
    step(2'b10, 2'b10, 2'b10, 0, 0, 2, 2, 1'b0, gany_t, g_t, ro);
    check("one_res_data", res_data, 32'h40800000);
    check("one_res_id", res_id, 1);
    check("one_busy", busy, 1);
    step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1, gany_t, g_t, ro);
    check("one_busy_after_pop", busy, 0);

    // Reset mid-accumulation
    do_reset(1);
    step(2'b01, 2'b01, 2'b00, 1, 2, 0, 0, 1'b0, gany_t, g_t, ro);
    do_reset(1);
    step(2'b01, 2'b00, 2'b01, 1, 1, 0, 0, 1'b0, gany_t, g_t, ro);
    check("rst_mid_res_data", res_data, 32'h3F800000);
    check("rst_mid_err_seq0", dut.err_seq[0], 1);

    // Stall counter
    do_reset(1);
    for (int i = 0; i < 10; i++)
      step(2'b11, 2'b11, 2'b00, 1, 1, 1, 1, 1'b0, gany_t, g_t, ro);
`ifdef MAC_SHARE_STALL_CNT_EN
    check("stall_10", stall_cnt, 10);
`else
    check("stall_10", stall_cnt, 0);
`endif

    // Randomized traffic
    do_reset(1);
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < 15; k++) begin
        int len;
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          term_t t;
          t.a = $urandom_range(0, 7);
          t.b = $urandom_range(0, 7);
          t.f = (j == 0) ? ($urandom_range(9) != 0) : 1'b0;
          t.l = (j == len - 1);
          if (ch == 0) q0.push_back(t);
          else q1.push_back(t);
        end
      end
    end
    run_queues(2000, 60, 25);
    for (int i = 0; i < 3; i++)
      step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1, gany_t, g_t, ro);
    check("rand_err_seq", dut.err_seq, {m_err[1], m_err[0]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_share_arbiter.md
MAC_SHARE_ARBITER -- requirements
Module: mac_share_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width (IEEE-754 single).
REQ-002 Parameter: CNT_W, 16, stall counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset; synchronous and active-low.
REQ-005 req_valid  input  2  per-requester term valid.
REQ-006 req_ready  output  2  per-requester grant; combinational, at most one bit set.
REQ-007 req_a, req_b  input  2xDATA_W  per-requester multiplicand operands.
REQ-008 req_first  input  2  term opens a new accumulation (addend forced to 0).
REQ-009 req_last  input  2  term closes the accumulation (result emitted).
REQ-010 mac_a, mac_b, mac_c  output  DATA_W each  operands to the shared external combinational FP MAC (z = a*b + c).
REQ-011 mac_rnd  output  3  rounding mode; constant 3'b000.
REQ-012 mac_z  input  DATA_W  MAC result, same cycle.
REQ-013 res_valid  output  1  result holding register valid.
REQ-014 res_ready  input  1  result consumer accepts.
REQ-015 res_data  output  DATA_W  accumulated result.
REQ-016 res_id  output  1  requester index of res_data.
REQ-017 busy  output  1  high while any accumulation is open or res_valid is high.
REQ-018 stall_cnt  output  CNT_W  stall counter (see Configuration).

Function
REQ-019 The block shares one MAC between two requesters; a term transfers when req_valid[i] and req_ready[i] are both high.
REQ-020 Eligibility: req_valid[i] high, and, if req_last[i] is high, the result register is free (res_valid low, or res_ready high this cycle).
REQ-021 Arbitration: round-robin pointer rr; the eligible requester equal to rr wins, otherwise the other eligible requester wins; after any grant, rr becomes the non-granted index.
REQ-022 Without a grant, mac_a, mac_b and mac_c are driven to 0.
REQ-023 On a grant to i, mac_a=req_a[i] and mac_b=req_b[i].
REQ-024 On a grant to i, mac_c=0 when req_first[i] is high or accumulation i is closed, else acc[i].
REQ-025 Per-requester state, CLOSED/OPEN: CLOSED->OPEN on a granted non-last term; OPEN->CLOSED on a granted last term; first+last on one term is a one-term accumulation that stays CLOSED.
REQ-026 A granted non-last term loads acc[i] with mac_z at the next edge.
REQ-027 A granted last term loads res_data with mac_z and res_id with i, sets res_valid at the next edge (latency 1 cycle), and clears acc[i] to 0.
REQ-028 res_valid clears on res_valid and res_ready with no new last grant; a simultaneous pop and last grant keeps res_valid high with the new data.
REQ-029 A non-first term arriving while CLOSED is accumulated onto 0 and sets the sticky flag err_seq[i] (internal, visible in simulation); the flag clears only on reset.
REQ-030 A non-last term is never blocked by a full result register; the other requester may continue accumulating.
REQ-031 Accumulator state of the non-granted requester is unaffected in any cycle.

Reset
REQ-032 reset_n low at an edge: rr=0, both requesters CLOSED, acc=0, res_valid=0, res_data=0, res_id=0, stall_cnt=0, err_seq=0.
REQ-033 Reset mid-accumulation discards partial sums; no result is emitted for them.
REQ-034 During reset the outputs req_ready=0, mac_* =0, busy=0.

Configuration
REQ-035 Macro MAC_SHARE_STALL_CNT_EN is the single compile-time option.
REQ-036 MAC_SHARE_STALL_CNT_EN defined: stall_cnt increments by one, saturating at all-ones, each cycle some req_valid bit is high but its req_ready bit is low.
REQ-037 MAC_SHARE_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter register exists.

Verification
REQ-038 Solo accumulation: ch0 terms (first, 1.0x2.0), then (last, 3.0x1.0) -> res_valid one cycle after the last grant, res_data=0x40A00000 (5.0), res_id=0.
REQ-039 Contention: both channels valid every cycle from reset, 2 terms each -> grants alternate 0,1,0,1; ch0 result res_data=0x40A00000 (5.0) and ch1 result correct.
REQ-040 Backpressure: res_valid high, res_ready=0, ch1 presents a last term while ch0 presents non-last terms -> req_ready[1]=0 and ch0 is granted every cycle; raising res_ready grants ch1 in the same cycle.
REQ-041 One-term accumulation: ch1 first+last 2.0x2.0 -> res_data=0x40800000 (4.0), ch1 stays CLOSED, busy drops after the pop.
REQ-042 Reset mid-operation: ch0 OPEN with acc=2.0, assert reset_n=0 for 1 cycle, then ch0 term (last, 1.0x1.0, first=0) -> res_data=0x3F800000 (1.0) and err_seq[0]=1.
REQ-043 Stall counter: with MAC_SHARE_STALL_CNT_EN, both channels valid for 10 cycles -> stall_cnt=10; without the macro, stall_cnt=0.
